// File: rtl/result_uart_tx.sv
// Serialises a p_N-bit result word as NB back-to-back UART frames, MSB byte first, LSB bit first.
// Optional build macro RESULT_UART_TX_PARITY_EN adds an even-parity bit (8E1 instead of 8N1).
module result_uart_tx #(
  parameter int clk_freq       = 50000000,
  parameter int uart_baud_rate = 57600,
  parameter int p_N            = 16
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [p_N-1:0] i_data,
  input  logic           i_start,
  output logic           o_busy,
  output logic           o_done,
  output logic           uart_txd
);

  localparam int DIV = clk_freq / uart_baud_rate;
  localparam int NB  = p_N / 8;
  localparam int CW  = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int BW  = (NB > 1) ? $clog2(NB) : 1;

  localparam logic [CW-1:0] BAUD_LAST = CW'(DIV - 1);
  localparam logic [CW-1:0] BAUD_ONE  = CW'(1);
  localparam logic [BW-1:0] BYTE_LAST = BW'(NB - 1);
  localparam logic [BW-1:0] BYTE_ONE  = BW'(1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
`ifdef RESULT_UART_TX_PARITY_EN
    S_PARITY,
`endif
    S_STOP
  } state_t;

  state_t         state_reg, state_next;
  logic [CW-1:0]  baud_reg, baud_next;
  logic [2:0]     bit_reg, bit_next;
  logic [BW-1:0]  byte_reg, byte_next;
  logic [p_N-1:0] shift_reg, shift_next;
  logic           txd_reg, txd_next;
  logic           busy_reg, busy_next;
  logic           done_reg, done_next;

  logic [7:0] cur_byte;
  logic [2:0] bit_inc;
  logic       baud_wrap;

  // The byte on the wire is always the top byte; later bytes are shifted up into place.
  assign cur_byte  = shift_reg[p_N-1 -: 8];
  assign bit_inc   = bit_reg + 3'd1;
  assign baud_wrap = (baud_reg == BAUD_LAST);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg <= S_IDLE;
      baud_reg  <= '0;
      bit_reg   <= '0;
      byte_reg  <= '0;
      shift_reg <= '0;
      txd_reg   <= 1'b1;
      busy_reg  <= 1'b0;
      done_reg  <= 1'b0;
    end else begin
      state_reg <= state_next;
      baud_reg  <= baud_next;
      bit_reg   <= bit_next;
      byte_reg  <= byte_next;
      shift_reg <= shift_next;
      txd_reg   <= txd_next;
      busy_reg  <= busy_next;
      done_reg  <= done_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    baud_next  = baud_wrap ? '0 : baud_reg + BAUD_ONE;
    bit_next   = bit_reg;
    byte_next  = byte_reg;
    shift_next = shift_reg;
    txd_next   = txd_reg;
    busy_next  = busy_reg;
    done_next  = 1'b0;

    case (state_reg)
      S_IDLE: begin
        baud_next = '0;
        txd_next  = 1'b1;
        busy_next = 1'b0;
        // Outputs are registered, so the start bit appears at the capturing edge.
        if (i_start) begin
          shift_next = i_data;
          bit_next   = '0;
          byte_next  = '0;
          txd_next   = 1'b0;
          busy_next  = 1'b1;
          state_next = S_START;
        end
      end

      S_START: begin
        if (baud_wrap) begin
          bit_next   = '0;
          txd_next   = cur_byte[0];
          state_next = S_DATA;
        end
      end

      S_DATA: begin
        if (baud_wrap) begin
          if (bit_reg == 3'd7) begin
`ifdef RESULT_UART_TX_PARITY_EN
            txd_next   = ^cur_byte;
            state_next = S_PARITY;
`else
            txd_next   = 1'b1;
            state_next = S_STOP;
`endif
          end else begin
            bit_next = bit_inc;
            txd_next = cur_byte[bit_inc];
          end
        end
      end

`ifdef RESULT_UART_TX_PARITY_EN
      S_PARITY: begin
        if (baud_wrap) begin
          txd_next   = 1'b1;
          state_next = S_STOP;
        end
      end
`endif

      S_STOP: begin
        if (baud_wrap) begin
          if (byte_reg == BYTE_LAST) begin
            byte_next  = '0;
            txd_next   = 1'b1;
            busy_next  = 1'b0;
            done_next  = 1'b1;
            state_next = S_IDLE;
          end else begin
            // Next frame follows the stop bit with no idle gap.
            byte_next  = byte_reg + BYTE_ONE;
            shift_next = shift_reg << 8;
            txd_next   = 1'b0;
            state_next = S_START;
          end
        end
      end

      default: begin
        txd_next   = 1'b1;
        busy_next  = 1'b0;
        state_next = S_IDLE;
      end
    endcase
  end

  assign o_busy   = busy_reg;
  assign o_done   = done_reg;
  assign uart_txd = txd_reg;

endmodule

// File: tb/tb_result_uart_tx.sv
// Scoreboarded bench for result_uart_tx: 16-bit word at 8 clocks/bit and 8-bit word at 4 clocks/bit.
// Honours RESULT_UART_TX_PARITY_EN for frame length and parity expectations.
module tb_result_uart_tx;

`ifdef RESULT_UART_TX_PARITY_EN
  localparam int F = 11;
  localparam logic [F-1:0] FRAME_A5 = 11'b10101001010;
`else
  localparam int F = 10;
  localparam logic [F-1:0] FRAME_A5 = 10'b1101001010;
`endif
  localparam int DIV16 = 8;
  localparam int DIV8  = 4;

  logic        clk;
  logic        rst;
  logic [15:0] data16;
  logic        start16, busy16, done16, txd16;
  logic [7:0]  data8;
  logic        start8, busy8, done8, txd8;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  logic [7:0]   exp16_q[$];
  logic [F-1:0] exp8_q[$];

  result_uart_tx #(.clk_freq(460800), .uart_baud_rate(57600), .p_N(16)) dut16 (
    .clk(clk), .rst(rst), .i_data(data16), .i_start(start16),
    .o_busy(busy16), .o_done(done16), .uart_txd(txd16)
  );

  result_uart_tx #(.clk_freq(230400), .uart_baud_rate(57600), .p_N(8)) dut8 (
    .clk(clk), .rst(rst), .i_data(data8), .i_start(start8),
    .o_busy(busy8), .o_done(done8), .uart_txd(txd8)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin : watchdog
    #1000000;
    $display("FAIL watchdog: time limit reached, got no summary required summary");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h required 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Issue a 16-bit transfer at the current negedge; expected bytes go to the scoreboard.
  task automatic launch16(input logic [15:0] w, input logic [7:0] hi, input logic [7:0] lo,
                          output int k);
    k = cyc + 1;
    start16 = 1'b1;
    data16  = w;
    exp16_q.push_back(hi);
    exp16_q.push_back(lo);
    @(negedge clk);
    start16 = 1'b0;
    data16  = 16'hDEAD;
    check("launch16_busy", 32'(busy16), 32'h1);
    check("launch16_txd", 32'(txd16), 32'h0);
    check("launch16_done", 32'(done16), 32'h0);
  endtask

  task automatic wait_done16(input int exp_end);
    int n;
    n = 0;
    while (done16 !== 1'b1 && n < 400) begin
      @(negedge clk);
      n++;
    end
    check("done16_time", 32'(cyc), 32'(exp_end));
    check("done16_busy", 32'(busy16), 32'h0);
    check("done16_txd", 32'(txd16), 32'h1);
  endtask

  // Line monitors: decode each frame sampling every cycle, then pop and compare.
  initial begin : mon16
    logic [F-1:0] bits;
    logic [F-1:0] exp_frame;
    logic [7:0]   e;
    logic         glitch, aborted;
    forever begin
      @(negedge clk);
      if (rst === 1'b1 && txd16 === 1'b0) begin
        glitch = 1'b0;
        aborted = 1'b0;
        bits = '0;
        for (int b = 0; b < F; b++) begin
          for (int j = 0; j < DIV16; j++) begin
            if (b != 0 || j != 0) @(negedge clk);
            if (rst !== 1'b1) aborted = 1'b1;
            if (j == 0) bits[b] = txd16;
            else if (txd16 !== bits[b]) glitch = 1'b1;
          end
        end
        if (!aborted) begin
          if (exp16_q.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL frame16_unexpected: got frame %b required no frame", bits);
          end else begin
            e = exp16_q.pop_front();
`ifdef RESULT_UART_TX_PARITY_EN
            exp_frame = {1'b1, ^e, e, 1'b0};
`else
            exp_frame = {1'b1, e, 1'b0};
`endif
            $display("frame16 byte 0x%02h bits %b", bits[8:1], bits);
            check("frame16_bits", 32'(bits), 32'(exp_frame));
            check("frame16_stable", 32'(glitch), 32'h0);
          end
        end
      end
    end
  end

  initial begin : mon8
    logic [F-1:0] bits;
    logic         glitch, aborted;
    forever begin
      @(negedge clk);
      if (rst === 1'b1 && txd8 === 1'b0) begin
        glitch = 1'b0;
        aborted = 1'b0;
        bits = '0;
        for (int b = 0; b < F; b++) begin
          for (int j = 0; j < DIV8; j++) begin
            if (b != 0 || j != 0) @(negedge clk);
            if (rst !== 1'b1) aborted = 1'b1;
            if (j == 0) bits[b] = txd8;
            else if (txd8 !== bits[b]) glitch = 1'b1;
          end
        end
        if (!aborted) begin
          if (exp8_q.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL frame8_unexpected: got frame %b required no frame", bits);
          end else begin
            $display("frame8 bits %b", bits);
            check("frame8_bits", 32'(bits), 32'(exp8_q.pop_front()));
            check("frame8_stable", 32'(glitch), 32'h0);
          end
        end
      end
    end
  end

  initial begin : stim
    int k, k2, n;
    rst = 1'b0;
    data16 = '0;
    start16 = 1'b0;
    data8 = '0;
    start8 = 1'b0;
    repeat (5) @(negedge clk);
    check("rst_txd16", 32'(txd16), 32'h1);
    check("rst_busy16", 32'(busy16), 32'h0);
    check("rst_done16", 32'(done16), 32'h0);
    check("rst_txd8", 32'(txd8), 32'h1);
    check("rst_busy8", 32'(busy8), 32'h0);
    rst = 1'b1;
    repeat (3) @(negedge clk);

    // Basic 0x1234: second start bit exactly one frame after the first.
    launch16(16'h1234, 8'h12, 8'h34, k);
    while (cyc < k + F * DIV16 - 1) @(negedge clk);
    check("basic_stop_bit", 32'(txd16), 32'h1);
    @(negedge clk);
    check("basic_second_start", 32'(txd16), 32'h0);
    check("basic_busy_mid", 32'(busy16), 32'h1);
    wait_done16(k + 2 * F * DIV16);
    @(negedge clk);
    check("basic_done_one_cycle", 32'(done16), 32'h0);

    // Request while busy is ignored.
    repeat (4) @(negedge clk);
    launch16(16'h1234, 8'h12, 8'h34, k);
    repeat (40) @(negedge clk);
    start16 = 1'b1;
    data16 = 16'hABCD;
    @(negedge clk);
    start16 = 1'b0;
    check("ignore_busy", 32'(busy16), 32'h1);
    wait_done16(k + 2 * F * DIV16);
    n = 0;
    repeat (3 * F * DIV16) begin
      @(negedge clk);
      if (done16 === 1'b1) n++;
    end
    check("ignore_extra_done", 32'(n), 32'h0);

    // Back-to-back: restart in the done cycle.
    launch16(16'h00FF, 8'h00, 8'hFF, k);
    wait_done16(k + 2 * F * DIV16);
    launch16(16'hFF00, 8'hFF, 8'h00, k2);
    wait_done16(k2 + 2 * F * DIV16);

    // Asynchronous reset during the data bits of the first byte.
    repeat (4) @(negedge clk);
    launch16(16'hFFFF, 8'hFF, 8'hFF, k);
    repeat (3 * DIV16) @(negedge clk);
    rst = 1'b0;
    #1;
    check("async_rst_txd", 32'(txd16), 32'h1);
    check("async_rst_busy", 32'(busy16), 32'h0);
    check("async_rst_done", 32'(done16), 32'h0);
    exp16_q.delete();
    repeat (3) @(negedge clk);
    rst = 1'b1;
    n = 0;
    repeat (200) begin
      @(negedge clk);
      if (txd16 !== 1'b1) n++;
    end
    check("idle_after_reset", 32'(n), 32'h0);

    // Single-byte instance, 0xA5 at 4 clocks per bit.
    k = cyc + 1;
    start8 = 1'b1;
    data8 = 8'hA5;
    exp8_q.push_back(FRAME_A5);
    @(negedge clk);
    start8 = 1'b0;
    check("p8_busy", 32'(busy8), 32'h1);
    check("p8_start_txd", 32'(txd8), 32'h0);
    n = 0;
    while (done8 !== 1'b1 && n < 200) begin
      @(negedge clk);
      n++;
    end
    check("p8_done_time", 32'(cyc), 32'(k + F * DIV8));
    check("p8_done_busy", 32'(busy8), 32'h0);
    @(negedge clk);
    check("p8_done_one_cycle", 32'(done8), 32'h0);

    repeat (10) @(negedge clk);
    check("q16_drained", 32'(exp16_q.size()), 32'h0);
    check("q8_drained", 32'(exp8_q.size()), 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
